// File: rtl/seq_complement2.sv
// Bit-serial two's-complement negator: one half-adder step per clock, LSB first.
// Optional SEQ_COMPLEMENT2_ABS_EN adds abs_mode (absolute value instead of negation).
module seq_complement2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SEQ_COMPLEMENT2_ABS_EN
    input  logic             abs_mode,
`endif
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   s,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned LAST  = WIDTH - 1;
    localparam logic [WIDTH-1:0] OP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               neg_q, neg_d;
    logic               busy_d, done_d, ovf_d;
    logic [WIDTH:0]     s_d;
    logic               a_bit, s_bit, carry_nx;
    logic               neg_req;

`ifdef SEQ_COMPLEMENT2_ABS_EN
    // Non-negative operands pass through unchanged in abs mode.
    assign neg_req = ~abs_mode | a[WIDTH-1];
`else
    assign neg_req = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            busy    <= busy_d;
            done    <= done_d;
            s       <= s_d;
            ovf     <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        neg_d    = neg_q;
        busy_d   = busy;
        done_d   = 1'b0;
        s_d      = s;
        ovf_d    = ovf;

        // Half-adder step on the current operand bit (~a + 1, carry-in preset to 1).
        a_bit    = op_q[cnt_q];
        s_bit    = neg_q ? (~a_bit ^ carry_q) : a_bit;
        carry_nx = neg_q & ~a_bit & carry_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = a;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    neg_d   = neg_req;
                    s_d     = '0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                s_d[WIDTH-1:0] = s[WIDTH-1:0] | (WIDTH'(s_bit) << cnt_q);
                carry_d        = carry_nx;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LAST)) begin
                    s_d[WIDTH] = carry_nx;
                    ovf_d      = neg_q & (op_q == OP_MIN);
                    cnt_d      = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_complement2.sv
// Self-checking bench for seq_complement2 (WIDTH=5) against an arithmetic reference model.
module tb_seq_complement2;

    localparam int unsigned W = 5;
`ifdef SEQ_COMPLEMENT2_ABS_EN
    localparam bit ABS_ON = 1'b1;
`else
    localparam bit ABS_ON = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abs_mode;
    logic [W-1:0] a;
    logic         busy;
    logic         done;
    logic [W:0]   s;
    logic         ovf;

    int n_assert = 0;
    int n_fail   = 0;

    seq_complement2 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef SEQ_COMPLEMENT2_ABS_EN
        .abs_mode (abs_mode),
`endif
        .a        (a),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result = 2^W - a as a (W+1)-bit number, or a itself in abs mode for non-negative a.
    function automatic logic [W:0] model_s(input logic [W-1:0] v, input logic am);
        int unsigned r;
        if (am && (v < (1 << (W - 1))))
            return (W+1)'(v);
        r = (1 << W) - int'(v);
        return (W+1)'(r);
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] v, input logic am);
        if (am && (v < (1 << (W - 1))))
            return 1'b0;
        return int'(v) == (1 << (W - 1));
    endfunction

    // One operation; checks busy/done every cycle and the result at the done cycle.
    task automatic run(input logic [W-1:0] val, input logic am, input bit scramble, input string tag);
        logic [W:0] exp_s;
        logic       exp_o;
        exp_s    = model_s(val, am & ABS_ON);
        exp_o    = model_ovf(val, am & ABS_ON);
        start    = 1'b1;
        a        = val;
        abs_mode = am;
        tick();
        start = 1'b0;
        for (int t = 1; t <= int'(W) + 2; t++) begin
            if (t > 1) begin
                if (scramble) a = W'($urandom);
                tick();
            end
            if (t < int'(W) + 2) begin
                chk({tag, "_done_low"}, 32'(done), 32'd0);
                chk({tag, "_busy_high"}, 32'(busy), 32'd1);
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_s"}, 32'(s), 32'(exp_s));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
    endtask

    initial begin
        int            ndone;
        logic [W:0]    s_at_done;
        int            t_done;
        logic [W-1:0]  order [32];

        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        abs_mode = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner values.
        run(5'b00000, 1'b0, 1'b0, "zero");
        chk("zero_s_exact", 32'(s), 32'b100000);
        run(5'b00001, 1'b0, 1'b0, "one");
        chk("one_s_exact", 32'(s), 32'b011111);
        run(5'b10000, 1'b0, 1'b0, "min");
        chk("min_ovf_exact", 32'(ovf), 32'd1);
        tick();
        chk("hold_s", 32'(s), 32'b010000);
        chk("hold_ovf", 32'(ovf), 32'd1);

        // Start during RUN must be ignored.
        start = 1'b1;
        a     = 5'b11111;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        a     = 5'b00011;
        tick();
        start     = 1'b0;
        ndone     = 0;
        t_done    = 0;
        s_at_done = '0;
        for (int t = 3; t <= 14; t++) begin
            if (done) begin
                ndone++;
                s_at_done = s;
                t_done    = t;
            end
            tick();
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_s", 32'(s_at_done), 32'b000001);
        chk("ign_latency", 32'(t_done), 32'd7);
        chk("ign_idle", 32'(busy), 32'd0);

        // Reset in the third RUN cycle aborts the operation.
        start = 1'b1;
        a     = 5'b00110;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_s", 32'(s), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (done) ndone++;
        end
        chk("mid_rst_nodone", 32'(ndone), 32'd0);
        run(5'b00110, 1'b0, 1'b0, "after_rst");
        chk("after_rst_exact", 32'(s), 32'b011010);

        if (ABS_ON) begin
            run(5'b00101, 1'b1, 1'b0, "abs_pos");
            chk("abs_pos_exact", 32'(s), 32'b000101);
            run(5'b11011, 1'b1, 1'b0, "abs_neg");
            chk("abs_neg_exact", 32'(s), 32'b000101);
        end

        // All operand values, shuffled, back-to-back, with a scrambled after acceptance.
        for (int i = 0; i < 32; i++) order[i] = W'(i);
        for (int i = 31; i > 0; i--) begin
            int j;
            logic [W-1:0] tmp;
            j        = int'($urandom_range(i, 0));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 32; i++) begin
            run(order[i], 1'b0, 1'b1, "sweep");
        end
        if (ABS_ON) begin
            for (int i = 0; i < 8; i++) begin
                run(W'($urandom), 1'($urandom), 1'b1, "abs_rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_complement2.md
SEQ_COMPLEMENT2 -- requirements
Module: seq_complement2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to complement the operand a; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: the operand, captured on the accepted start.
REQ-006 The block SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse when s and ovf become valid.
REQ-008 The block SHALL have port s, output, WIDTH+1 bits: two's complement of a in s[WIDTH-1:0], with the final carry-out in s[WIDTH].
REQ-009 The block SHALL have port ovf, output, 1 bit: high when a is the most-negative value (1 followed by WIDTH-1 zeros).

Function
REQ-010 The block SHALL be a bit-serial negator with the FSM states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1, the block SHALL latch a into an operand register, clear the bit counter, set the carry register to 1, and go to RUN.
REQ-012 In each RUN cycle for bit i (LSB first), the block SHALL compute s[i] = ~a[i] XOR carry and carry_next = ~a[i] AND carry (one half-adder step per cycle).
REQ-013 When i = WIDTH-1 completes, the block SHALL write s[WIDTH] = carry_next and go to DONE.
REQ-014 In DONE, the block SHALL assert done for exactly one cycle and return to IDLE.
REQ-015 Latency SHALL be fixed: with start accepted at edge 0, done is high in the cycle after edge WIDTH+1, for a total of WIDTH+2 cycles start-to-start.
REQ-016 A start while busy=1 SHALL be ignored, with no effect on the operand, the counter or s.
REQ-017 Changes on a after acceptance SHALL NOT affect the result.
REQ-018 s and ovf SHALL hold their last values from the end of DONE until the next accepted start.
REQ-019 On an accepted start, s SHALL be cleared to 0 before the RUN bits are written, so a partial result never shows stale bits.
REQ-020 ovf SHALL be computed from the latched operand and SHALL update together with s[WIDTH].
REQ-021 For a = 0, the result SHALL be s[WIDTH-1:0] = 0 with s[WIDTH] = 1.
REQ-022 For all other a, s[WIDTH] SHALL be 0.
REQ-023 Back-to-back operation SHALL be supported: a start in the cycle after done is accepted.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously force state=IDLE, busy=0, done=0, s=0, ovf=0, and clear the counter and carry.
REQ-025 A reset mid-RUN SHALL abort the operation with no done pulse; after release the block accepts start on the first clock edge.

Configuration
REQ-026 With the macro SEQ_COMPLEMENT2_ABS_EN defined, the block SHALL add the input abs_mode (1 bit, latched with a).
REQ-027 With SEQ_COMPLEMENT2_ABS_EN defined, abs_mode=1 and a[WIDTH-1]=0, the block SHALL pass a through unchanged (s[WIDTH]=0, ovf=0) with identical latency.
REQ-028 With SEQ_COMPLEMENT2_ABS_EN defined, abs_mode=1 and a[WIDTH-1]=1, the block SHALL negate as in REQ-012.
REQ-029 Without SEQ_COMPLEMENT2_ABS_EN, the abs_mode port SHALL be absent and the block SHALL always negate.

Verification (WIDTH=5)
REQ-030 The bench SHALL check a=00000, start -> after 7 cycles done=1, s=100000, ovf=0.
REQ-031 The bench SHALL check a=00001 -> s=011111, ovf=0.
REQ-032 The bench SHALL check a=10000 -> s=010000, ovf=1.
REQ-033 The bench SHALL check a=11111, then a second start with a=00011 during RUN -> s=000001, exactly one done, and the second start ignored.
REQ-034 The bench SHALL check a=00110, with rst_n pulsed low in the third RUN cycle -> busy=0 and s=0 immediately, no done, and a next start with a=00110 gives s=011010.
REQ-035 The bench SHALL check, with the macro defined, abs_mode=1, a=00101 -> s=000101; and abs_mode=1, a=11011 -> s=000101.
REQ-036 The bench SHALL run all 32 values of a and check s[4:0] = (32-a) mod 32, s[5] = (a==0), ovf = (a==16).
